// File: rtl/clk_counter.sv
// clk_counter: prescaled wrapping counter.
// count advances once per CLOCK_DELAY clk edges, wrapping past COUNT_LIMIT.
module clk_counter #(
  parameter int COUNT_LIMIT       = 9,
  parameter int COUNT_WIDTH       = 4,
  parameter int CLOCK_DELAY       = 10,
  parameter int CLOCK_DELAY_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [COUNT_WIDTH-1:0] count
);

  if (COUNT_LIMIT < 0 ||
      COUNT_LIMIT > (2**COUNT_WIDTH) - 1) begin : g_bad_limit
    $error("COUNT_LIMIT does not fit COUNT_WIDTH");
  end

  if (CLOCK_DELAY < 1 ||
      CLOCK_DELAY - 1 > (2**CLOCK_DELAY_WIDTH) - 1) begin : g_bad_delay
    $error("CLOCK_DELAY does not fit CLOCK_DELAY_WIDTH");
  end

  localparam logic [CLOCK_DELAY_WIDTH-1:0] PS_LAST =
    CLOCK_DELAY_WIDTH'(CLOCK_DELAY - 1);
  localparam logic [COUNT_WIDTH-1:0] LIMIT =
    COUNT_WIDTH'(COUNT_LIMIT);
  localparam logic [CLOCK_DELAY_WIDTH-1:0] PS_ONE =
    CLOCK_DELAY_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE =
    COUNT_WIDTH'(1);

  logic [CLOCK_DELAY_WIDTH-1:0] prescale;
  logic                         tick;
  logic                         at_limit;

  assign tick     = (prescale == PS_LAST);
  // >= so an out-of-range count also falls back to 0
  assign at_limit = (count >= LIMIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prescale <= '0;
      count    <= '0;
    end else if (tick) begin
      prescale <= '0;
      count    <= at_limit ? '0 : count + CNT_ONE;
    end else begin
      prescale <= prescale + PS_ONE;
    end
  end

endmodule

// File: tb/tb_clk_counter.sv
// tb_clk_counter: directed checks of clk_counter.
// Four parameterisations share one clock and one reset.
`timescale 1ns/1ps
module tb_clk_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] cnt_def;
  logic [3:0] cnt_fast;
  logic [3:0] cnt_full;
  logic [3:0] cnt_zero;

  int checks   = 0;
  int failures = 0;

  // 12 MHz
  always #41.667 clk = ~clk;

  clk_counter u_def (
    .clk   (clk),
    .rst   (rst),
    .count (cnt_def)
  );

  clk_counter #(
    .COUNT_LIMIT       (3),
    .COUNT_WIDTH       (4),
    .CLOCK_DELAY       (1),
    .CLOCK_DELAY_WIDTH (4)
  ) u_fast (
    .clk   (clk),
    .rst   (rst),
    .count (cnt_fast)
  );

  clk_counter #(
    .COUNT_LIMIT       (15),
    .COUNT_WIDTH       (4),
    .CLOCK_DELAY       (2),
    .CLOCK_DELAY_WIDTH (1)
  ) u_full (
    .clk   (clk),
    .rst   (rst),
    .count (cnt_full)
  );

  clk_counter #(
    .COUNT_LIMIT       (0),
    .COUNT_WIDTH       (4),
    .CLOCK_DELAY       (10),
    .CLOCK_DELAY_WIDTH (4)
  ) u_zero (
    .clk   (clk),
    .rst   (rst),
    .count (cnt_zero)
  );

  task automatic do_reset();
    rst = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [3:0] exp0;
    exp0 = 4'd0;
    rst = 1'b0;
    #5;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if ({cnt_def, cnt_fast, cnt_full, cnt_zero}
          !== {4{exp0}}) begin
        failures++;
        $display("FAIL reset_hold edge=%0d got=%h/%h/%h/%h want=0",
                 i, cnt_def, cnt_fast, cnt_full, cnt_zero);
      end
    end
  endtask

  task automatic test_default_run();
    logic [3:0] exp;
    do_reset();
    for (int e = 1; e <= 200; e++) begin
      step();
      exp = 4'((e / 10) % 10);
      checks++;
      if (cnt_def !== exp) begin
        failures++;
        $display("FAIL default_run edge=%0d got=%0d want=%0d",
                 e, cnt_def, exp);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [3:0] exp;
    do_reset();
    for (int e = 1; e <= 55; e++) step();
    exp = 4'd5;
    checks++;
    if (cnt_def !== exp) begin
      failures++;
      $display("FAIL mid_pre edge=55 got=%0d want=%0d", cnt_def, exp);
    end
    #10;
    rst = 1'b0;
    #1;
    exp = 4'd0;
    checks++;
    if (cnt_def !== exp) begin
      failures++;
      $display("FAIL async_reset got=%0d want=0", cnt_def);
    end
    checks++;
    if (cnt_full !== exp || cnt_fast !== exp) begin
      failures++;
      $display("FAIL async_reset_others got=%0d/%0d want=0",
               cnt_fast, cnt_full);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      step();
      exp = (e == 10) ? 4'd1 : 4'd0;
      checks++;
      if (cnt_def !== exp) begin
        failures++;
        $display("FAIL mid_post edge=%0d got=%0d want=%0d",
                 e, cnt_def, exp);
      end
    end
  endtask

  task automatic test_fast();
    logic [3:0] exp;
    do_reset();
    for (int e = 1; e <= 9; e++) begin
      step();
      exp = 4'(e % 4);
      checks++;
      if (cnt_fast !== exp) begin
        failures++;
        $display("FAIL fast edge=%0d got=%0d want=%0d",
                 e, cnt_fast, exp);
      end
    end
  endtask

  task automatic test_full_wrap();
    logic [3:0] exp;
    do_reset();
    for (int e = 1; e <= 70; e++) begin
      step();
      exp = 4'((e / 2) % 16);
      checks++;
      if (cnt_full !== exp) begin
        failures++;
        $display("FAIL full_wrap edge=%0d got=%h want=%h",
                 e, cnt_full, exp);
      end
    end
  endtask

  task automatic test_zero_limit();
    logic [3:0] exp;
    exp = 4'd0;
    do_reset();
    for (int e = 1; e <= 50; e++) begin
      step();
      checks++;
      if (cnt_zero !== exp) begin
        failures++;
        $display("FAIL zero_limit edge=%0d got=%0d want=0",
                 e, cnt_zero);
      end
    end
  endtask

  initial begin
    test_reset();
    test_default_run();
    test_mid_reset();
    test_fast();
    test_full_wrap();
    test_zero_limit();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
